// File: rtl/vec_tx_pkg.sv
// Shared definitions for the vector serial transmitter: FSM encoding, default
// geometry and pointer sizing.
package vec_tx_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DEPTH = 256;
    localparam int unsigned DEF_LANES = 4;

    typedef logic [1:0] state_t;

    localparam state_t FILL = 2'd0;
    localparam state_t SEND = 2'd1;
    localparam state_t DONE = 2'd2;

    // One extra bit so a pointer can hold DEPTH itself (end-of-frame marker).
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vec_tx_buf.sv
// Simple dual-port frame buffer: one synchronous write port, one registered
// synchronous read port, no reset so it maps onto block RAM.
module vec_tx_buf
    import vec_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vec_ser_tx.sv
// Collects one DEPTH-word frame from the upstream serial stream, then replays
// it as a back-pressured word stream with last/group-end markers.
module vec_ser_tx
    import vec_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned LANES = DEF_LANES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gvalid,
    input  logic             ivalid,
    input  logic [WIDTH-1:0] in,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_last,
    output logic             tx_group_end,
    output logic             done,
    output logic             overflow
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_END  = PW'(DEPTH);

    state_t          state_q, state_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            gend_q, gend_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            load, rd_en, wr_en, accept;
    logic [WIDTH-1:0] rd_data;

    assign load   = gvalid && (state_q == SEND) && (!valid_q || tx_ready);
    assign rd_en  = load && (rptr_q < PTR_END);
    assign wr_en  = gvalid && (state_q == FILL) && ivalid;
    assign accept = valid_q && tx_ready && last_q;

    vec_tx_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr_q[AW-1:0]),
        .wdata (in),
        .re    (rd_en),
        .raddr (rptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        valid_d = valid_q;
        last_d  = last_q;
        gend_d  = gend_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        if (!gvalid) begin
            state_d = FILL;
            wptr_d  = '0;
            rptr_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            gend_d  = 1'b0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (ivalid) begin
                        wptr_d = wptr_q + 1'b1;
                        if (wptr_q == LAST_IDX) begin
                            state_d = SEND;
                            rptr_d  = '0;
                        end
                    end
                end
                SEND: begin
                    if (ivalid) begin
                        ovf_d = 1'b1;
                    end
                    if (accept) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        gend_d  = 1'b0;
                    end else if (rd_en) begin
                        valid_d = 1'b1;
                        last_d  = (rptr_q == LAST_IDX);
                        gend_d  = ((32'(rptr_q) % LANES) == (LANES - 1));
                        rptr_d  = rptr_q + 1'b1;
                    end else if (load) begin
                        valid_d = 1'b0;
                    end
                end
                DONE: begin
                    if (ivalid) begin
                        ovf_d = 1'b1;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            gend_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            gend_q  <= gend_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // The RAM read register has no reset; masking with valid keeps tx_data at
    // zero after reset/clear while staying stable under back-pressure.
    assign tx_data      = valid_q ? rd_data : '0;
    assign tx_valid     = valid_q;
    assign tx_last      = last_q;
    assign tx_group_end = gend_q;
    assign done         = done_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_vec_ser_tx.sv
// Scoreboard bench for vec_ser_tx with an 8-word frame and 4-word groups.
module tb_vec_ser_tx;
    import vec_tx_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LANES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             gvalid;
    logic             ivalid;
    logic [WIDTH-1:0] din;
    logic             tx_ready;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_last;
    logic             tx_group_end;
    logic             done;
    logic             overflow;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
        logic             gend;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int first_valid, last_accept, done_cycle, accepted;

    always #5 clk = ~clk;

    vec_ser_tx #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LANES (LANES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gvalid       (gvalid),
        .ivalid       (ivalid),
        .in           (din),
        .tx_ready     (tx_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_group_end (tx_group_end),
        .done         (done),
        .overflow     (overflow)
    );

    // Writes one frame; returns right after driving the last word.
    task automatic fill_frame(input logic [WIDTH-1:0] base, input int gap);
        exp_t e;
        for (int i = 0; i < int'(DEPTH); i++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                ivalid = 1'b0;
                checks++;
                if (dut.state_q !== FILL || tx_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_gap word %0d: state=%0d tx_valid=%b, want state=%0d tx_valid=0",
                             i, dut.state_q, tx_valid, FILL);
                end
            end
            @(negedge clk);
            checks++;
            if (dut.state_q !== FILL || tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL fill word %0d: state=%0d tx_valid=%b, want state=%0d tx_valid=0",
                         i, dut.state_q, tx_valid, FILL);
            end
            ivalid = 1'b1;
            din    = base + WIDTH'(i);
            e.data = base + WIDTH'(i);
            e.last = (i == int'(DEPTH) - 1);
            e.gend = ((i % int'(LANES)) == int'(LANES) - 1);
            sb.push_back(e);
        end
    endtask

    // pattern 0: ready always; 1: ready on cycles 0,3,6,... (1,0,0,1,...)
    task automatic drain(input int pattern, input int stop_after, input int inject_cyc);
        int   cyc;
        logic rdy;
        cyc = 0;
        accepted = 0;
        first_valid = -1;
        last_accept = -1;
        done_cycle = -1;
        while (cyc < 200) begin
            @(negedge clk);
            ivalid = (cyc == inject_cyc);
            din    = (cyc == inject_cyc) ? 16'hFFFF : 16'h0000;
            if (tx_valid === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word cyc %0d: got data=%h, want no word", cyc, tx_data);
                end else if ({tx_data, tx_last, tx_group_end} !== sb[0]) begin
                    errors++;
                    $display("FAIL word cyc %0d: got data=%h last=%b gend=%b, want data=%h last=%b gend=%b",
                             cyc, tx_data, tx_last, tx_group_end, sb[0].data, sb[0].last, sb[0].gend);
                end
            end
            if (done === 1'b1) begin
                done_cycle = cyc;
                checks++;
                if (sb.size() != 0 || tx_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL done_early cyc %0d: pending=%0d tx_valid=%b, want pending=0 tx_valid=0",
                             cyc, sb.size(), tx_valid);
                end
                break;
            end
            rdy = (pattern == 0) ? 1'b1 : ((cyc % 3) == 0);
            tx_ready = rdy;
            if (tx_valid === 1'b1 && rdy && sb.size() > 0) begin
                void'(sb.pop_front());
                accepted++;
                last_accept = cyc;
                if (stop_after > 0 && accepted == stop_after) return;
            end
            cyc++;
        end
        ivalid = 1'b0;
        if (done_cycle < 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: done=%b after %0d cycles, want done=1", done, cyc);
        end
    endtask

    task automatic clear_frame();
        @(negedge clk);
        gvalid   = 1'b0;
        ivalid   = 1'b0;
        tx_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_valid, tx_data, tx_last, tx_group_end, done, overflow} !== '0) begin
            errors++;
            $display("FAIL clear_outputs: got valid=%b data=%h last=%b gend=%b done=%b ovf=%b, want all 0",
                     tx_valid, tx_data, tx_last, tx_group_end, done, overflow);
        end
        gvalid = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; gvalid = 1'b1; ivalid = 1'b0; din = '0; tx_ready = 1'b0;
        #3;
        checks++;
        if ({tx_valid, tx_data, tx_last, tx_group_end, done, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h last=%b gend=%b done=%b ovf=%b, want all 0",
                     tx_valid, tx_data, tx_last, tx_group_end, done, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        fill_frame(16'h0001, 0);
        drain(0, 0, -1);
        checks++;
        if (first_valid != 1 || last_accept != 8 || done_cycle != 9) begin
            errors++;
            $display("FAIL basic_timing: first=%0d last=%0d done=%0d, want first=1 last=8 done=9",
                     first_valid, last_accept, done_cycle);
        end
    endtask

    task automatic test_back_pressure();
        clear_frame();
        fill_frame(16'h0001, 0);
        drain(1, 0, -1);
        checks++;
        if (accepted != int'(DEPTH) || done_cycle != last_accept + 1) begin
            errors++;
            $display("FAIL bp_done: accepted=%0d done=%0d last=%0d, want accepted=8 done=last+1",
                     accepted, done_cycle, last_accept);
        end
    endtask

    task automatic test_gapped();
        clear_frame();
        fill_frame(16'h0001, 1);
        drain(0, 0, -1);
        checks++;
        if (first_valid != 1 || accepted != int'(DEPTH)) begin
            errors++;
            $display("FAIL gapped: first=%0d accepted=%0d, want first=1 accepted=8",
                     first_valid, accepted);
        end
    endtask

    task automatic test_overflow();
        clear_frame();
        fill_frame(16'h0001, 0);
        drain(0, 0, 3);
        checks++;
        if (overflow !== 1'b1 || accepted != int'(DEPTH)) begin
            errors++;
            $display("FAIL overflow_set: ovf=%b accepted=%0d, want ovf=1 accepted=8",
                     overflow, accepted);
        end
        clear_frame();
    endtask

    task automatic test_mid_clear();
        clear_frame();
        fill_frame(16'h0001, 0);
        drain(0, 3, -1);
        @(negedge clk);
        gvalid = 1'b0;
        ivalid = 1'b1;
        din    = 16'hAAAA;
        tx_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({tx_valid, tx_data, tx_last, tx_group_end, done, overflow} !== '0) begin
                errors++;
                $display("FAIL mid_clear_outputs %0d: got valid=%b data=%h last=%b done=%b ovf=%b, want all 0",
                         k, tx_valid, tx_data, tx_last, done, overflow);
            end
        end
        ivalid = 1'b0;
        gvalid = 1'b1;
        sb.delete();
        fill_frame(16'h0011, 0);
        drain(0, 0, -1);
        checks++;
        if (first_valid != 1 || accepted != int'(DEPTH)) begin
            errors++;
            $display("FAIL refill: first=%0d accepted=%0d, want first=1 accepted=8",
                     first_valid, accepted);
        end
    endtask

    task automatic test_async_reset();
        clear_frame();
        fill_frame(16'h0001, 0);
        drain(0, 2, -1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({tx_valid, tx_data, tx_last, tx_group_end, done, overflow} !== '0 ||
            dut.state_q !== FILL) begin
            errors++;
            $display("FAIL async_reset: got valid=%b data=%h last=%b done=%b state=%0d, want all 0 state=%0d",
                     tx_valid, tx_data, tx_last, done, dut.state_q, FILL);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        fill_frame(16'h0021, 0);
        drain(0, 0, -1);
        checks++;
        if (first_valid != 1 || accepted != int'(DEPTH)) begin
            errors++;
            $display("FAIL after_reset: first=%0d accepted=%0d, want first=1 accepted=8",
                     first_valid, accepted);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_gapped();
        test_overflow();
        test_mid_clear();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
